mont_arbiter: RTL and testbench

MONT_ARBITER -- requirements
Module: mont_arbiter

---
 rtl/rsa_pkg.sv | 17 +
 rtl/rr_arb2.sv | 23 ++
 rtl/mont_arbiter.sv | 145 ++++++++++++++
 tb/tb_mont_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
//   RSA_WIDTH            default operand/result width in bits
//   DEFAULT_MONT_TIMEOUT default engine-cycle budget per Montgomery operation
//   arb_state_t          state encoding of the Montgomery engine arbiter
package rsa_pkg;

    localparam int RSA_WIDTH            = 256;
    localparam int DEFAULT_MONT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
//   req          per-requester request bits
//   ptr          requester favoured when both request
//   grant_valid  at least one request present
//   grant_idx    index of the chosen requester
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ptr;
        end else begin
            grant_idx = req[1];
        end
    end

endmodule

// File: rtl/mont_arbiter.sv
// Arbiter sharing one Montgomery multiplier engine between two requesters.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request; grant and latch operands on entry out
//   ISSUE  | one-cycle engine start pulse, timeout counter cleared
//   WAIT   | waiting for engine finish or timeout
//   RESP   | one-cycle done pulse to the owner, round-robin pointer flips
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_req[1:0]                requests, held until the matching o_done
//   i_a0/i_b0, i_a1/i_b1      per-requester operands
//   i_n                       modulus
//   o_done[1:0], o_err        completion pulse, timeout flag (with o_done)
//   o_result                  last captured engine result
//   o_busy, o_owner           not-idle flag, current/last granted requester
//   o_eng_start               engine start pulse
//   o_eng_a/b/n               registered engine operands
//   i_eng_result, i_eng_finished  engine result and finish pulse
module mont_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH   = RSA_WIDTH,
    parameter int TIMEOUT = DEFAULT_MONT_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    input  logic [WIDTH-1:0] i_n,
    output logic [1:0]       o_done,
    output logic             o_err,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy,
    output logic             o_owner,
    output logic             o_eng_start,
    output logic [WIDTH-1:0] o_eng_a,
    output logic [WIDTH-1:0] o_eng_b,
    output logic [WIDTH-1:0] o_eng_n,
    input  logic [WIDTH-1:0] i_eng_result,
    input  logic             i_eng_finished
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             ptr;
    logic             err_q;
    logic             grant_valid;
    logic             grant_idx;

    rr_arb2 u_rr_arb2 (
        .req         (i_req),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ptr      <= 1'b0;
            err_q    <= 1'b0;
            o_owner  <= 1'b0;
            o_result <= '0;
            o_eng_a  <= '0;
            o_eng_b  <= '0;
            o_eng_n  <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        o_owner <= grant_idx;
                        o_eng_a <= grant_idx ? i_a1 : i_a0;
                        o_eng_b <= grant_idx ? i_b1 : i_b0;
                        o_eng_n <= i_n;
                    end
                end
                ST_ISSUE: begin
                    cnt <= '0;
                end
                ST_WAIT: begin
                    // A finish in the last budgeted cycle still counts as success.
                    if (i_eng_finished) begin
                        o_result <= i_eng_result;
                        err_q    <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        err_q    <= 1'b1;
                    end
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    ptr <= ~o_owner;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        o_eng_start = 1'b0;
        o_done      = 2'b00;
        o_err       = 1'b0;
        o_busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (grant_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_eng_start = 1'b1;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_eng_finished || (cnt == CNT_LAST)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                o_done     = o_owner ? 2'b10 : 2'b01;
                o_err      = err_q;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mont_arbiter.sv
module tb_mont_arbiter;

    localparam int W        = 256;
    localparam int TO_SHORT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, default timeout
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1, n;
    logic [1:0]   done;
    logic         err;
    logic [W-1:0] result;
    logic         busy, owner, eng_start;
    logic [W-1:0] eng_a, eng_b, eng_n;
    logic [W-1:0] eng_result;
    logic         eng_fin;

    // short-timeout instance
    logic [1:0]   req_t;
    logic [W-1:0] a_t, zero_w;
    logic [1:0]   done_t;
    logic         err_t;
    logic [W-1:0] result_t;
    logic         busy_t, owner_t, start_t;
    logic [W-1:0] eng_a_t, eng_b_t, eng_n_t;
    logic [W-1:0] res_t;
    logic         fin_t;

    int checks   = 0;
    int failures = 0;

    mont_arbiter #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1), .i_n(n),
        .o_done(done), .o_err(err), .o_result(result),
        .o_busy(busy), .o_owner(owner), .o_eng_start(eng_start),
        .o_eng_a(eng_a), .o_eng_b(eng_b), .o_eng_n(eng_n),
        .i_eng_result(eng_result), .i_eng_finished(eng_fin)
    );

    mont_arbiter #(.WIDTH(W), .TIMEOUT(TO_SHORT)) dut_t (
        .i_clk(clk), .i_rst(rst), .i_req(req_t),
        .i_a0(a_t), .i_b0(a_t), .i_a1(zero_w), .i_b1(zero_w), .i_n(zero_w),
        .o_done(done_t), .o_err(err_t), .o_result(result_t),
        .o_busy(busy_t), .o_owner(owner_t), .o_eng_start(start_t),
        .o_eng_a(eng_a_t), .o_eng_b(eng_b_t), .o_eng_n(eng_n_t),
        .i_eng_result(res_t), .i_eng_finished(fin_t)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a start pulse on the main instance.
    task automatic wait_start(output bit ok);
        int guard;
        guard = 0;
        while (!eng_start && guard < 20) begin
            step();
            guard++;
        end
        ok = eng_start;
    endtask

    // Engine model: finishes `delay` cycles after the start cycle with `res`.
    // Returns in the done cycle; lat is cycles from start to done (-1 if none).
    task automatic serve(input int delay, input logic [W-1:0] res,
                         output logic [1:0] done_v, output int lat,
                         output logic [W-1:0] ea, output logic [W-1:0] eb,
                         output logic own, output int starts);
        bit ok;
        done_v = 2'b00; lat = -1; ea = '0; eb = '0; own = 1'b0; starts = 0;
        wait_start(ok);
        if (!ok) return;
        starts = 1;
        ea = eng_a; eb = eng_b; own = owner;
        for (int k = 1; k <= delay; k++) begin
            step();
            if (eng_start) starts++;
        end
        eng_result = res;
        eng_fin    = 1'b1;
        step();
        eng_fin = 1'b0;
        lat     = delay + 1;
        while (done == 2'b00 && lat < delay + 20) begin
            step();
            lat++;
            if (eng_start) starts++;
        end
        if (done != 2'b00) done_v = done;
        else lat = -1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        step();
        checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", eng_start); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b exp=0", owner); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%0h exp=0", result); end
        checks++; if ((eng_a | eng_b | eng_n) !== '0) begin failures++; $display("FAIL reset_operands got=%0h/%0h/%0h exp=0", eng_a, eng_b, eng_n); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [1:0] dv; int lat; logic [W-1:0] ea, eb; logic own; int starts;
        req = 2'b01; a0 = W'(3); b0 = W'(5); n = W'('h61);
        serve(256, W'('h0F), dv, lat, ea, eb, own, starts);
        checks++; if (starts !== 1) begin failures++; $display("FAIL single_starts got=%0d exp=1", starts); end
        checks++; if (lat !== 257) begin failures++; $display("FAIL single_latency got=%0d exp=257", lat); end
        checks++; if (dv !== 2'b01) begin failures++; $display("FAIL single_done got=%b exp=01", dv); end
        checks++; if (result !== W'('h0F)) begin failures++; $display("FAIL single_result got=%0h exp=f", result); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
        checks++; if (ea !== W'(3) || eb !== W'(5)) begin failures++; $display("FAIL single_operands got=%0h/%0h exp=3/5", ea, eb); end
        checks++; if (eng_n !== W'('h61)) begin failures++; $display("FAIL single_mod got=%0h exp=61", eng_n); end
        req = 2'b00;
        step();
        checks++; if (busy !== 1'b0 || done !== 2'b00) begin failures++; $display("FAIL single_idle got busy=%b done=%b exp=0/00", busy, done); end
        checks++; if (result !== W'('h0F)) begin failures++; $display("FAIL single_result_hold got=%0h exp=f", result); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] dv; int lat; logic [W-1:0] ea, eb; logic own; int starts;
        do_reset();
        a0 = W'('h11); b0 = W'('h22); a1 = W'('h33); b1 = W'('h44);
        req = 2'b11;
        serve(4, W'('h100), dv, lat, ea, eb, own, starts);
        checks++; if (own !== 1'b0) begin failures++; $display("FAIL simul_first_owner got=%b exp=0", own); end
        checks++; if (ea !== W'('h11) || eb !== W'('h22)) begin failures++; $display("FAIL simul_first_ops got=%0h/%0h exp=11/22", ea, eb); end
        checks++; if (dv !== 2'b01 || lat !== 5) begin failures++; $display("FAIL simul_first_done got=%b lat=%0d exp=01 lat=5", dv, lat); end
        req[0] = 1'b0;
        serve(4, W'('h200), dv, lat, ea, eb, own, starts);
        checks++; if (own !== 1'b1) begin failures++; $display("FAIL simul_second_owner got=%b exp=1", own); end
        checks++; if (ea !== W'('h33) || eb !== W'('h44)) begin failures++; $display("FAIL simul_second_ops got=%0h/%0h exp=33/44", ea, eb); end
        checks++; if (dv !== 2'b10 || result !== W'('h200)) begin failures++; $display("FAIL simul_second_done got=%b res=%0h exp=10 res=200", dv, result); end
        req = 2'b00;
        step();
    endtask

    task automatic test_fairness();
        logic [1:0] dv; int lat; logic [W-1:0] ea, eb; logic own; int starts;
        logic exp_own;
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_own = logic'(i % 2);
            serve(2, W'(32'h30 + i), dv, lat, ea, eb, own, starts);
            checks++; if (own !== exp_own) begin failures++; $display("FAIL fair_owner op=%0d got=%b exp=%b", i, own, exp_own); end
            checks++; if (dv !== (exp_own ? 2'b10 : 2'b01)) begin failures++; $display("FAIL fair_done op=%0d got=%b exp_owner=%b", i, dv, exp_own); end
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_timeout();
        int guard; int lat;
        do_reset();
        a_t = W'('h9);
        req_t = 2'b01;
        guard = 0;
        while (!start_t && guard < 20) begin step(); guard++; end
        checks++; if (start_t !== 1'b1) begin failures++; $display("FAIL to_first_start got=%b exp=1", start_t); end
        for (int k = 1; k <= 3; k++) step();
        res_t = W'('h5A); fin_t = 1'b1;
        step();
        fin_t = 1'b0;
        checks++; if (done_t !== 2'b01 || err_t !== 1'b0 || result_t !== W'('h5A)) begin failures++; $display("FAIL to_normal got done=%b err=%b res=%0h exp=01/0/5a", done_t, err_t, result_t); end
        req_t = 2'b00;
        step();
        req_t = 2'b01; res_t = W'('hBAD);
        guard = 0;
        while (!start_t && guard < 20) begin step(); guard++; end
        lat = 0;
        while (done_t == 2'b00 && lat < 40) begin step(); lat++; end
        checks++; if (lat !== 17) begin failures++; $display("FAIL to_latency got=%0d exp=17", lat); end
        checks++; if (done_t !== 2'b01 || err_t !== 1'b1) begin failures++; $display("FAIL to_done got done=%b err=%b exp=01/1", done_t, err_t); end
        checks++; if (result_t !== W'('h5A)) begin failures++; $display("FAIL to_result_kept got=%0h exp=5a", result_t); end
        req_t = 2'b00;
        step();
        checks++; if (err_t !== 1'b0 || busy_t !== 1'b0) begin failures++; $display("FAIL to_after got err=%b busy=%b exp=0/0", err_t, busy_t); end
    endtask

    task automatic test_spurious();
        do_reset();
        eng_result = W'('hDEAD); eng_fin = 1'b1;
        step();
        eng_fin = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 2'b00 || result !== '0) begin failures++; $display("FAIL spur_idle got busy=%b done=%b res=%0h exp=0/00/0", busy, done, result); end
        req = 2'b01; a0 = W'(7); b0 = W'(9);
        step();
        checks++; if (eng_start !== 1'b1) begin failures++; $display("FAIL spur_issue_start got=%b exp=1", eng_start); end
        eng_fin = 1'b1;
        step();
        eng_fin = 1'b0;
        checks++; if (eng_start !== 1'b0 || busy !== 1'b1 || done !== 2'b00) begin failures++; $display("FAIL spur_issue_next got start=%b busy=%b done=%b exp=0/1/00", eng_start, busy, done); end
        step();
        checks++; if (done !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL spur_wait got done=%b busy=%b exp=00/1", done, busy); end
        eng_result = W'('h77); eng_fin = 1'b1;
        step();
        eng_fin = 1'b0;
        checks++; if (done !== 2'b01 || result !== W'('h77) || err !== 1'b0) begin failures++; $display("FAIL spur_real got done=%b res=%0h err=%b exp=01/77/0", done, result, err); end
        req = 2'b00;
        step();
    endtask

    task automatic test_reset_mid();
        bit ok; bit saw_done;
        req = 2'b10; a1 = W'('hA1); b1 = W'('hB1); n = W'('h65);
        wait_start(ok);
        checks++; if (!ok || owner !== 1'b1) begin failures++; $display("FAIL rmid_grant got start=%0d owner=%b exp=1/1", ok, owner); end
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        checks++; if (done !== 2'b00 || err !== 1'b0 || eng_start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got done=%b err=%b start=%b busy=%b exp=all 0", done, err, eng_start, busy); end
        checks++; if (owner !== 1'b0 || result !== '0 || (eng_a | eng_b | eng_n) !== '0) begin failures++; $display("FAIL rmid_data got owner=%b res=%0h a=%0h exp=0", owner, result, eng_a); end
        rst = 1'b0; req = 2'b00;
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done != 2'b00 || busy) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin failures++; $display("FAIL rmid_quiet got activity=1 exp=0"); end
        req = 2'b10;
        wait_start(ok);
        checks++; if (!ok || owner !== 1'b1 || eng_a !== W'('hA1)) begin failures++; $display("FAIL rmid_regrant got start=%0d owner=%b a=%0h exp=1/1/a1", ok, owner, eng_a); end
        step();
        eng_result = W'('h42); eng_fin = 1'b1;
        step();
        eng_fin = 1'b0;
        checks++; if (done !== 2'b10 || result !== W'('h42)) begin failures++; $display("FAIL rmid_done got done=%b res=%0h exp=10/42", done, result); end
        req = 2'b00;
        step();
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; eng_fin = 1'b0; eng_result = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; n = '0;
        req_t = 2'b00; a_t = '0; zero_w = '0; res_t = '0; fin_t = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
